// File: rtl/aes_dec_pkg.sv
// Shared definitions for the masked AES-128 decryption controller.
package aes_dec_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } dec_state_e;

   localparam int unsigned CYCLES_PER_ROUND = 7;
   localparam logic [2:0]  CNT_LAST         = 3'(CYCLES_PER_ROUND - 1);

   localparam logic [7:0]  RCON_DEC_FIRST   = 8'h36;
   localparam logic [7:0]  RCON_DEC_LAST    = 8'h01;
   // x^-1 in GF(2^8): shifting out a 1 folds back x^8+x^4+x^3+x+1 divided by x
   localparam logic [7:0]  RCON_INV_POLY    = 8'h8D;

   // Bit n set means InvShiftRows is applied in round slot n
   localparam logic [7:0]  DO_ISR_SLOTS     = 8'b0010_1010;

   function automatic logic [7:0] rcon_xinv(input logic [7:0] r);
      return r[0] ? ((r >> 1) ^ RCON_INV_POLY) : (r >> 1);
   endfunction

endpackage

// File: rtl/aes_dec_rcon_inv_gen.sv
// Round-constant register walking Rcon downward (multiply by x^-1) once per step.
module rcon_inv_gen
   import aes_dec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       step,
   output logic [7:0] Rcon
);

   logic [7:0] rcon_q, rcon_d;

   // Next constant: reload the first round value, step down, or hold
   always_comb begin
      rcon_d = rcon_q;
      if (clear) begin
         rcon_d = RCON_DEC_FIRST;
      end else if (step) begin
         rcon_d = rcon_xinv(rcon_q);
      end
   end

   // Rcon register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rcon_q <= RCON_DEC_FIRST;
      end else begin
         rcon_q <= rcon_d;
      end
   end

   assign Rcon = rcon_q;

endmodule

// File: rtl/aes_dec_controller.sv
// Sequencing controller for the half-pipelined masked AES-128 decryption datapath.
// One start runs the initial AddRoundKey plus 10 inverse rounds of CYCLES_PER_ROUND cycles.
module aes_dec_controller
   import aes_dec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       KeyMuxSel,
   output logic       InputMuxSel,
   output logic       StateEN,
   output logic       SboxInputSelector,
   output logic       KeyRegEn,
   output logic       LoadKeySchedule,
   output logic       ShowRcon,
   output logic       DoISR,
   output logic       FinalRound,
   output logic [7:0] Rcon,
   output logic       busy,
   output logic       done
);

   dec_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       slot_last;
   logic       rcon_clear;
   logic       rcon_step;

   assign slot_last  = (cnt_q == CNT_LAST);
   // Rcon is reloaded outside RUN so IDLE always shows the first-round constant
   assign rcon_clear = (state_q != StRun);
   assign rcon_step  = (state_q == StRun) && slot_last;

   rcon_inv_gen u_rcon_inv_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (rcon_clear),
      .step  (rcon_step),
      .Rcon  (Rcon)
   );

   // State and round-slot counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = 3'd0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            cnt_d = slot_last ? 3'd0 : cnt_q + 3'd1;
            if (slot_last && (Rcon == RCON_DEC_LAST)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control decode from state, slot and current Rcon
   always_comb begin
      KeyMuxSel         = 1'b0;
      InputMuxSel       = 1'b0;
      StateEN           = 1'b0;
      SboxInputSelector = 1'b0;
      KeyRegEn          = 1'b0;
      LoadKeySchedule   = 1'b0;
      ShowRcon          = 1'b0;
      DoISR             = 1'b0;
      FinalRound        = 1'b0;
      busy              = 1'b0;
      done              = 1'b0;
      unique case (state_q)
         StRun: begin
            busy              = 1'b1;
            StateEN           = 1'b1;
            // Slot 2 lends the shared S-box to SubWord, so the key register waits
            KeyRegEn          = (cnt_q != 3'd2);
            SboxInputSelector = (cnt_q == 3'd2);
            DoISR             = DO_ISR_SLOTS[cnt_q];
            LoadKeySchedule   = slot_last || (cnt_q == 3'd0);
            ShowRcon          = slot_last;
            KeyMuxSel         = (Rcon == RCON_DEC_FIRST) && (cnt_q < 3'd2);
            InputMuxSel       = (Rcon == RCON_DEC_FIRST);
            FinalRound        = (Rcon == RCON_DEC_LAST);
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
      // Clear the key register alongside the controller during reset
      if (rst) begin
         KeyRegEn = 1'b1;
      end
   end

endmodule
